gps_code_sequencer: RTL and testbench
=====================================

Name: gps_code_sequencer

Overview:
- Run-control sequencer for the GPS code generators on the fast GPS clock (10.23 MHz nominal).
- Loads the selected SV number into the code generators and waits for their ready.
- Then issues P-code chip enables every cycle and C/A chip enables every CA_DIV cycles.
- Tracks the C/A chip index, 1 ms epochs and 20 ms nav-bit boundaries; stops cleanly on an epoch boundary.

Parameters:
CA_DIV, 10, fast-clock cycles per C/A chip (>=2)
CA_LEN, 1023, C/A chips per epoch
EPB, 20, epochs per nav bit
TIMEOUT, 1024, max cycles waiting for gen_ready

Ports:
gps_clk_fast  in  1  fast GPS clock
gps_rst_n  in  1  reset, asynchronous, active-low
start  in  1  one-cycle start request, sampled only in IDLE
stop  in  1  one-cycle stop request
sv_num_in  in  6  SV select, latched on accepted start
gen_ready  in  1  code generators initialised (level)
code_load  out  1  one-cycle init pulse to code generators
sv_num  out  6  latched SV number
busy  out  1  state != IDLE
running  out  1  state == RUN
p_en  out  1  P-code chip enable
ca_en  out  1  C/A chip enable
chip_idx  out  10  current C/A chip, 0..CA_LEN-1
epoch  out  1  last chip of epoch (coincident with ca_en)
epoch_idx  out  5  epoch within bit, 0..EPB-1
bit_edge  out  1  last epoch of bit (coincident with epoch)
err  out  1  sticky gen_ready timeout flag

Behaviour:
- Clock is gps_clk_fast only; reset is asynchronous and active-low on gps_rst_n.
- Reset: state IDLE; all outputs 0; sv_num=0; internal counters and stop_pend cleared.
- FSM states: IDLE, LOAD, WAIT_RDY, RUN.
- IDLE:
  - On start=1: latch sv_num_in into sv_num, clear err, go to LOAD.
  - stop is ignored.
- LOAD:
  - code_load=1 for exactly this one cycle.
  - Timeout counter cleared; go to WAIT_RDY.
- WAIT_RDY:
  - On gen_ready=1: go to RUN, clearing prescaler, chip_idx, epoch_idx and stop_pend.
  - If gen_ready is still 0 when the counter reaches TIMEOUT-1: set err, go to IDLE.
  - On stop=1 (priority over gen_ready): go to IDLE, err unchanged.
- RUN:
  - p_en=1 every cycle.
  - Prescaler counts 0..CA_DIV-1 and wraps.
  - ca_en = running && prescaler==CA_DIV-1; decoded from registered state, no input-to-output path.
  - On ca_en, chip_idx increments; it wraps CA_LEN-1 -> 0.
  - epoch = ca_en && chip_idx==CA_LEN-1.
  - On epoch, epoch_idx increments; it wraps EPB-1 -> 0.
  - bit_edge = epoch && epoch_idx==EPB-1.
  - First ca_en falls in the CA_DIV-th RUN cycle (RUN entry cycle counts as 1).
  - First epoch falls in RUN cycle CA_DIV*CA_LEN.
- Stop in RUN:
  - stop=1 sets stop_pend.
  - The cycle with epoch=1 && (stop_pend || stop) is the last RUN cycle; the next cycle is IDLE with all counters 0.
  - Stop in the same cycle as epoch ends that epoch; no partial epoch is ever emitted.
- start outside IDLE is ignored; repeated stop pulses have no extra effect.
- gen_ready deasserting during RUN is ignored.
- Reset asserted mid-operation forces the reset state immediately (async); enables drop the same instant.
- Only the registers that drive code_load, busy and running are updated by the state transition. p_en, ca_en, epoch and bit_edge are 0 in every non-RUN state.
- chip_idx is 10 bits and epoch_idx is 5 bits. Parameter values must fit these widths, enforced by elaboration check.

Test Plan:
- Reset then start with sv_num_in=6'd5, gen_ready tied 1 -> code_load high 1 cycle, sv_num=5; running from the third cycle after start; p_en=1 every RUN cycle.
- Defaults, RUN entered -> ca_en in RUN cycles 10, 20, …; chip_idx=1 after the first; epoch with chip_idx=1022 in cycle 10230; bit_edge with epoch_idx=19 in cycle 204600.
- Stop pulse at RUN cycle 5000 -> running stays 1 until cycle 10230 (epoch), IDLE at 10231; chip_idx=0, epoch_idx=0, no further ca_en.
- gen_ready held 0 -> after 1024 WAIT_RDY cycles err=1, busy=0; the next accepted start clears err.
- Stop in WAIT_RDY, and a separate start during RUN -> stop returns to IDLE with err=0; start in RUN has no effect on counters or sv_num.
- gps_rst_n pulsed low mid-epoch (chip_idx=500) -> all outputs 0 asynchronously; after release, state IDLE, and a new start begins from chip 0.

Source files
------------

// File: rtl/gps_code_sequencer.sv
// Run-control sequencer for the GPS code generators: loads the SV number, waits
// for generator ready, then paces P/C/A chip enables and tracks epochs and nav bits.
module gps_code_sequencer #(
    parameter int unsigned CA_DIV  = 10,
    parameter int unsigned CA_LEN  = 1023,
    parameter int unsigned EPB     = 20,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic       gps_clk_fast,
    input  logic       gps_rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic [5:0] sv_num_in,
    input  logic       gen_ready,
    output logic       code_load,
    output logic [5:0] sv_num,
    output logic       busy,
    output logic       running,
    output logic       p_en,
    output logic       ca_en,
    output logic [9:0] chip_idx,
    output logic       epoch,
    output logic [4:0] epoch_idx,
    output logic       bit_edge,
    output logic       err
);

    localparam int unsigned PW = $clog2(CA_DIV);
    localparam int unsigned TW = $clog2(TIMEOUT);

    // Counter widths are fixed by the port list; reject parameters that would overflow them.
    if (CA_DIV < 2 || CA_LEN < 1 || CA_LEN > 1024 || EPB < 1 || EPB > 32 || TIMEOUT < 2) begin : g_param_check
        $error("gps_code_sequencer: parameter out of range");
    end

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_LOAD     = 2'd1,
        S_WAIT_RDY = 2'd2,
        S_RUN      = 2'd3
    } state_t;

    state_t        r_state;
    logic          r_code_load;
    logic [5:0]    r_sv_num;
    logic          r_busy;
    logic          r_running;
    logic          r_err;
    logic          r_stop_pend;
    logic [PW-1:0] r_presc;
    logic [TW-1:0] r_tmo;
    logic [9:0]    r_chip;
    logic [4:0]    r_epoch_idx;

    logic w_ca_en;
    logic w_epoch;
    logic w_bit_edge;
    logic w_last_run;

    // Enables decode purely from registers so they vanish with the async reset.
    assign w_ca_en    = r_running && (r_presc == PW'(CA_DIV - 1));
    assign w_epoch    = w_ca_en && (r_chip == 10'(CA_LEN - 1));
    assign w_bit_edge = w_epoch && (r_epoch_idx == 5'(EPB - 1));
    assign w_last_run = w_epoch && (r_stop_pend || stop);

    always_ff @(posedge gps_clk_fast or negedge gps_rst_n) begin
        if (!gps_rst_n) begin
            r_state     <= S_IDLE;
            r_code_load <= 1'b0;
            r_sv_num    <= '0;
            r_busy      <= 1'b0;
            r_running   <= 1'b0;
            r_err       <= 1'b0;
            r_stop_pend <= 1'b0;
            r_presc     <= '0;
            r_tmo       <= '0;
            r_chip      <= '0;
            r_epoch_idx <= '0;
        end else begin
            r_code_load <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_sv_num    <= sv_num_in;
                        r_err       <= 1'b0;
                        r_code_load <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_tmo   <= '0;
                    r_state <= S_WAIT_RDY;
                end
                S_WAIT_RDY: begin
                    if (stop) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (gen_ready) begin
                        r_presc     <= '0;
                        r_chip      <= '0;
                        r_epoch_idx <= '0;
                        r_stop_pend <= 1'b0;
                        r_running   <= 1'b1;
                        r_state     <= S_RUN;
                    end else if (r_tmo == TW'(TIMEOUT - 1)) begin
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_tmo <= r_tmo + TW'(1);
                    end
                end
                S_RUN: begin
                    r_presc     <= w_ca_en ? '0 : r_presc + PW'(1);
                    r_stop_pend <= r_stop_pend || stop;
                    if (w_ca_en) begin
                        r_chip <= w_epoch ? '0 : r_chip + 10'd1;
                    end
                    if (w_epoch) begin
                        r_epoch_idx <= w_bit_edge ? '0 : r_epoch_idx + 5'd1;
                    end
                    // A pending stop only takes effect on an epoch boundary.
                    if (w_last_run) begin
                        r_presc     <= '0;
                        r_chip      <= '0;
                        r_epoch_idx <= '0;
                        r_stop_pend <= 1'b0;
                        r_busy      <= 1'b0;
                        r_running   <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_busy    <= 1'b0;
                    r_running <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign code_load = r_code_load;
    assign sv_num    = r_sv_num;
    assign busy      = r_busy;
    assign running   = r_running;
    assign p_en      = r_running;
    assign ca_en     = w_ca_en;
    assign chip_idx  = r_chip;
    assign epoch     = w_epoch;
    assign epoch_idx = r_epoch_idx;
    assign bit_edge  = w_bit_edge;
    assign err       = r_err;

endmodule

// File: tb/tb_gps_code_sequencer.sv
// Bench for gps_code_sequencer: directed run/stop/timeout/reset steps with random
// timing, checked against run-cycle arithmetic.
module tb_gps_code_sequencer;

    localparam int unsigned P_DIV = 3;
    localparam int unsigned P_LEN = 7;
    localparam int unsigned P_EPB = 4;
    localparam int unsigned P_TMO = 16;
    localparam int E_LEN = P_DIV * P_LEN;
    localparam int B_LEN = E_LEN * P_EPB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [5:0] sv_num_in = '0;
    logic       gen_ready = 1'b0;
    logic       code_load, busy, running, p_en, ca_en, epoch, bit_edge, err;
    logic [5:0] sv_num;
    logic [9:0] chip_idx;
    logic [4:0] epoch_idx;

    int         n_cmp = 0;
    int         n_mis = 0;
    logic [5:0] exp_sv = '0;

    gps_code_sequencer #(
        .CA_DIV(P_DIV), .CA_LEN(P_LEN), .EPB(P_EPB), .TIMEOUT(P_TMO)
    ) dut (
        .gps_clk_fast(clk), .gps_rst_n(rst_n), .start(start), .stop(stop),
        .sv_num_in(sv_num_in), .gen_ready(gen_ready), .code_load(code_load),
        .sv_num(sv_num), .busy(busy), .running(running), .p_en(p_en),
        .ca_en(ca_en), .chip_idx(chip_idx), .epoch(epoch), .epoch_idx(epoch_idx),
        .bit_edge(bit_edge), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag, input logic exp_err);
        chk({tag, ".busy"}, 32'(busy), 32'(0));
        chk({tag, ".running"}, 32'(running), 32'(0));
        chk({tag, ".p_en"}, 32'(p_en), 32'(0));
        chk({tag, ".ca_en"}, 32'(ca_en), 32'(0));
        chk({tag, ".epoch"}, 32'(epoch), 32'(0));
        chk({tag, ".bit_edge"}, 32'(bit_edge), 32'(0));
        chk({tag, ".chip_idx"}, 32'(chip_idx), 32'(0));
        chk({tag, ".epoch_idx"}, 32'(epoch_idx), 32'(0));
        chk({tag, ".code_load"}, 32'(code_load), 32'(0));
        chk({tag, ".err"}, 32'(err), 32'(exp_err));
    endtask

    // Expected outputs in RUN cycle n (entry cycle is n=1), from chip/epoch arithmetic.
    task automatic check_run(input int n);
        chk("run.running", 32'(running), 32'(1));
        chk("run.busy", 32'(busy), 32'(1));
        chk("run.p_en", 32'(p_en), 32'(1));
        chk("run.ca_en", 32'(ca_en), 32'((n % P_DIV) == 0));
        chk("run.chip_idx", 32'(chip_idx), 32'(((n - 1) / P_DIV) % P_LEN));
        chk("run.epoch", 32'(epoch), 32'((n % E_LEN) == 0));
        chk("run.epoch_idx", 32'(epoch_idx), 32'(((n - 1) / E_LEN) % P_EPB));
        chk("run.bit_edge", 32'(bit_edge), 32'((n % B_LEN) == 0));
        chk("run.sv_num", 32'(sv_num), 32'(exp_sv));
    endtask

    // Start from IDLE, gen_ready arrives in WAIT_RDY cycle d+1; returns in RUN cycle 1.
    task automatic do_start(input logic [5:0] sv, input int d);
        start = 1'b1;
        sv_num_in = sv;
        gen_ready = 1'b0;
        tick();
        start = 1'b0;
        sv_num_in = 6'($urandom);
        exp_sv = sv;
        chk("load.code_load", 32'(code_load), 32'(1));
        chk("load.busy", 32'(busy), 32'(1));
        chk("load.running", 32'(running), 32'(0));
        chk("load.sv_num", 32'(sv_num), 32'(sv));
        chk("load.err", 32'(err), 32'(0));
        tick();
        for (int i = 0; i < d; i++) begin
            chk("wait.code_load", 32'(code_load), 32'(0));
            chk("wait.running", 32'(running), 32'(0));
            chk("wait.busy", 32'(busy), 32'(1));
            tick();
        end
        gen_ready = 1'b1;
        chk("wait.p_en", 32'(p_en), 32'(0));
        tick();
    endtask

    // Run from RUN cycle 1 with a stop pulse in cycle n_s; the run ends on the next epoch.
    task automatic run_and_stop(input int n_s, input int n_junk);
        int last;
        last = ((n_s + E_LEN - 1) / E_LEN) * E_LEN;
        for (int n = 1; n <= last; n++) begin
            check_run(n);
            stop = (n == n_s) || (n == n_s + 2);
            start = (n == n_junk);
            sv_num_in = 6'($urandom);
            gen_ready = 1'($urandom);
            tick();
        end
        stop = 1'b0;
        start = 1'b0;
        gen_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check_idle("stopped", 1'b0);
            chk("stopped.sv_num", 32'(sv_num), 32'(exp_sv));
            tick();
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset", 1'b0);
        chk("reset.sv_num", 32'(sv_num), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Run past a nav-bit edge, stop mid-epoch, start pulse during RUN ignored.
        do_start(6'd5, 0);
        run_and_stop(B_LEN + 1 + int'($urandom_range(0, B_LEN - 2)), 40);

        // Stop exactly on an epoch cycle ends that epoch.
        do_start(6'($urandom), int'($urandom_range(0, 5)));
        run_and_stop(E_LEN * int'($urandom_range(1, 6)), 7);

        // gen_ready never arrives: timeout sets err after P_TMO WAIT_RDY cycles.
        start = 1'b1;
        sv_num_in = 6'd9;
        gen_ready = 1'b0;
        tick();
        start = 1'b0;
        tick();
        for (int k = 1; k <= P_TMO; k++) begin
            chk("tmo.busy", 32'(busy), 32'(1));
            chk("tmo.err", 32'(err), 32'(0));
            tick();
        end
        check_idle("tmo.done", 1'b1);
        tick();
        chk("tmo.sticky", 32'(err), 32'(1));

        // Next accepted start clears err; then stop in WAIT_RDY beats gen_ready.
        start = 1'b1;
        sv_num_in = 6'd33;
        tick();
        start = 1'b0;
        chk("clr.err", 32'(err), 32'(0));
        chk("clr.sv_num", 32'(sv_num), 32'(33));
        tick();
        tick();
        stop = 1'b1;
        gen_ready = 1'b1;
        tick();
        stop = 1'b0;
        check_idle("wstop", 1'b0);

        // Async reset mid-epoch, then a fresh run starts from chip 0.
        tick();
        do_start(6'($urandom), int'($urandom_range(0, 3)));
        for (int n = 1; n <= P_DIV * 3 + 1; n++) begin
            check_run(n);
            tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("arst", 1'b0);
        chk("arst.sv_num", 32'(sv_num), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_idle("arst.rel", 1'b0);
        do_start(6'd17, 1);
        for (int n = 1; n <= E_LEN + 2; n++) begin
            check_run(n);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
